// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: state encoding and
// the default reset PC / bubble instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch/decode handshake bundle for the IF/ID register; the master side is
// the environment (fetch + decode), the slave side is the pipeline register.
interface if_id_skid_reg_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_npc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_npc;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output in_valid, in_npc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_npc, out_instr, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_npc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_npc, out_instr, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// One load-enabled {valid, npc, instr} holding register with a synchronous
// active-low clear that restores the reset PC and bubble instruction.
module pipe_entry_reg #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  CLR_NPC   = '0,
  parameter logic [INSTR_W-1:0] CLR_INSTR = '0
) (
  input  logic               clock,
  input  logic               i_clr_n,
  input  logic               i_load,
  input  logic               i_valid,
  input  logic [ADDR_W-1:0]  i_npc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_npc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [ADDR_W-1:0]  r_npc;
  logic [INSTR_W-1:0] r_instr;

  always_ff @(posedge clock) begin
    if (!i_clr_n) begin
      r_valid <= 1'b0;
      r_npc   <= CLR_NPC;
      r_instr <= CLR_INSTR;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_npc   <= i_npc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_npc   = r_npc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional statistics counters are enabled by defining IF_ID_PIPE_STATS_EN.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic           clock,
  input  logic           reset,
  if_id_skid_reg_if.slave bus
);

  state_e r_state, w_state_nxt;

  logic               w_clr_n;
  logic               w_accept;
  logic               w_deliver;

  logic               w_main_load;
  logic               w_main_vld_d;
  logic [ADDR_W-1:0]  w_main_npc_d;
  logic [INSTR_W-1:0] w_main_instr_d;
  logic               w_main_vld;
  logic [ADDR_W-1:0]  w_main_npc;
  logic [INSTR_W-1:0] w_main_instr;

  logic               w_skid_load;
  logic               w_skid_vld_d;
  logic               w_skid_vld;
  logic [ADDR_W-1:0]  w_skid_npc;
  logic [INSTR_W-1:0] w_skid_instr;

  // Flush shares the clear path with reset so both restore RESET_PC/NOP.
  assign w_clr_n   = reset & ~bus.flush;
  assign w_accept  = bus.in_valid & ~w_skid_vld;
  assign w_deliver = w_main_vld & bus.out_ready;

  always_ff @(posedge clock) begin
    if (!w_clr_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_main_load    = 1'b0;
    w_main_vld_d   = 1'b0;
    w_main_npc_d   = bus.in_npc;
    w_main_instr_d = bus.in_instr;
    w_skid_load    = 1'b0;
    w_skid_vld_d   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_load  = 1'b1;
          w_main_vld_d = 1'b1;
          w_state_nxt  = FULL;
        end
      end
      FULL: begin
        if (w_accept && w_deliver) begin
          w_main_load  = 1'b1;
          w_main_vld_d = 1'b1;
        end else if (w_accept) begin
          w_skid_load  = 1'b1;
          w_skid_vld_d = 1'b1;
          w_state_nxt  = SKID;
        end else if (w_deliver) begin
          // Drain to a bubble: keep the last npc, show the NOP instruction.
          w_main_load    = 1'b1;
          w_main_npc_d   = w_main_npc;
          w_main_instr_d = NOP_INSTR;
          w_state_nxt    = EMPTY;
        end
      end
      SKID: begin
        if (w_deliver) begin
          w_main_load    = 1'b1;
          w_main_vld_d   = 1'b1;
          w_main_npc_d   = w_skid_npc;
          w_main_instr_d = w_skid_instr;
          w_skid_load    = 1'b1;
          w_state_nxt    = FULL;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  pipe_entry_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .CLR_NPC   (RESET_PC),
    .CLR_INSTR (NOP_INSTR)
  ) u_main (
    .clock   (clock),
    .i_clr_n (w_clr_n),
    .i_load  (w_main_load),
    .i_valid (w_main_vld_d),
    .i_npc   (w_main_npc_d),
    .i_instr (w_main_instr_d),
    .o_valid (w_main_vld),
    .o_npc   (w_main_npc),
    .o_instr (w_main_instr)
  );

  pipe_entry_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .CLR_NPC   (RESET_PC),
    .CLR_INSTR (NOP_INSTR)
  ) u_skid (
    .clock   (clock),
    .i_clr_n (w_clr_n),
    .i_load  (w_skid_load),
    .i_valid (w_skid_vld_d),
    .i_npc   (bus.in_npc),
    .i_instr (bus.in_instr),
    .o_valid (w_skid_vld),
    .o_npc   (w_skid_npc),
    .o_instr (w_skid_instr)
  );

  assign bus.in_ready  = ~w_skid_vld;
  assign bus.out_valid = w_main_vld;
  assign bus.out_npc   = w_main_npc;
  assign bus.out_instr = w_main_instr;

`ifdef IF_ID_PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_main_vld && !bus.out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
      // A valid main entry is present whenever anything at all is held.
      if (bus.flush && w_main_vld)      r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
